mem_access_stage: RTL and testbench

//  Pipeline MEM stage. Sits between the EX/MEM register and the MEM/WB register and produces the mem_info stream that MEM/WB latches.

---
 rtl/mem_access_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues LA32 loads/stores on the req/addr_ok/data_ok bus,
// steers store lanes, extracts/extends load data and produces the MEM/WB stream.
module mem_access_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_valid,
  output logic              ts_ready,
  input  logic              ns_ready,
  output logic              ts_valid,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_inst,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic [3:0]        ex_lsu_op,
  input  logic [4:0]        ex_rw_addr,
  input  logic              ex_rw_en,
  output logic [DATA_W-1:0] mem_pc,
  output logic [DATA_W-1:0] mem_inst,
  output logic [DATA_W-1:0] mem_rw_data,
  output logic [4:0]        mem_rw_addr,
  output logic              mem_rw_en,
  output logic              mem_ale,
  output logic              dm_req,
  output logic              dm_wr,
  output logic [3:0]        dm_wstrb,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_addr_ok,
  input  logic              dm_data_ok,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam logic [3:0] OP_LD_B  = 4'd1, OP_LD_H  = 4'd2, OP_LD_W = 4'd3;
  localparam logic [3:0] OP_LD_BU = 4'd4, OP_LD_HU = 4'd5;
  localparam logic [3:0] OP_ST_B  = 4'd6, OP_ST_H  = 4'd7, OP_ST_W = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CANCEL} state_t;
  state_t state_q, state_d;

  logic              ts_valid_q, ts_valid_d;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] addr_q, pc_q, inst_q;
  logic [4:0]        rwa_q;
  logic              rwe_q, wr_q;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mem_pc_q, mem_inst_q, mem_rw_data_q;
  logic [4:0]        mem_rw_addr_q;
  logic              mem_rw_en_q, mem_ale_q;

  logic is_b, is_h, is_w, is_st, misalign, accept, go_req, complete;
  logic [DATA_W-1:0] ld_shift, ld_val;

  always_comb begin
    is_b     = (ex_lsu_op == OP_LD_B) || (ex_lsu_op == OP_LD_BU) || (ex_lsu_op == OP_ST_B);
    is_h     = (ex_lsu_op == OP_LD_H) || (ex_lsu_op == OP_LD_HU) || (ex_lsu_op == OP_ST_H);
    is_w     = (ex_lsu_op == OP_LD_W) || (ex_lsu_op == OP_ST_W);
    is_st    = (ex_lsu_op >= OP_ST_B) && (ex_lsu_op <= OP_ST_W);
    misalign = (is_h && ex_result[0]) || (is_w && (ex_result[1:0] != 2'b00));
  end

  assign ts_ready = (state_q == IDLE) && (!ts_valid_q || ns_ready);
  assign accept   = ls_valid && ts_ready && !flush;
  assign go_req   = accept && (is_b || is_h || is_w) && !misalign;
  // A response that arrives together with a flush is simply discarded.
  assign complete = !flush && (((state_q == REQ) && dm_addr_ok && dm_data_ok) ||
                               ((state_q == WAIT) && dm_data_ok));

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = '0;
    if (is_st) begin
      if (is_b) begin
        wstrb_d = 4'b0001 << ex_result[1:0];
        wdata_d = {4{ex_st_data[7:0]}};
      end else if (is_h) begin
        wstrb_d = 4'b0011 << ex_result[1:0];
        wdata_d = {2{ex_st_data[15:0]}};
      end else begin
        wstrb_d = 4'b1111;
        wdata_d = ex_st_data;
      end
    end
  end

  assign ld_shift = dm_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_val = dm_rdata;
    case (op_q)
      OP_LD_B:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      OP_LD_BU: ld_val = {24'd0, ld_shift[7:0]};
      OP_LD_H:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      OP_LD_HU: ld_val = {16'd0, ld_shift[15:0]};
      default:  ld_val = dm_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (go_req) state_d = REQ;
      REQ: begin
        if (dm_addr_ok) begin
          if (dm_data_ok)  state_d = IDLE;
          else if (flush)  state_d = CANCEL;
          else             state_d = WAIT;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dm_data_ok)  state_d = IDLE;
        else if (flush)  state_d = CANCEL;
      end
      CANCEL: if (dm_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ts_valid_d = ts_valid_q;
    if (flush)                               ts_valid_d = 1'b0;
    else if ((accept && !go_req) || complete) ts_valid_d = 1'b1;
    else if (ns_ready)                       ts_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ts_valid_q    <= 1'b0;
      op_q          <= 4'd0;
      addr_q        <= '0;
      pc_q          <= '0;
      inst_q        <= '0;
      rwa_q         <= 5'd0;
      rwe_q         <= 1'b0;
      wr_q          <= 1'b0;
      wstrb_q       <= 4'd0;
      wdata_q       <= '0;
      mem_pc_q      <= '0;
      mem_inst_q    <= '0;
      mem_rw_data_q <= '0;
      mem_rw_addr_q <= 5'd0;
      mem_rw_en_q   <= 1'b0;
      mem_ale_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_valid_q <= ts_valid_d;
      if (go_req) begin
        op_q    <= ex_lsu_op;
        addr_q  <= ex_result;
        pc_q    <= ex_pc;
        inst_q  <= ex_inst;
        rwa_q   <= ex_rw_addr;
        rwe_q   <= ex_rw_en;
        wr_q    <= is_st;
        wstrb_q <= wstrb_d;
        wdata_q <= wdata_d;
      end
      if (accept && !go_req) begin
        mem_pc_q      <= ex_pc;
        mem_inst_q    <= ex_inst;
        mem_rw_data_q <= ex_result;
        mem_rw_addr_q <= ex_rw_addr;
        mem_rw_en_q   <= ex_rw_en && !misalign;
        mem_ale_q     <= misalign;
      end else if (complete) begin
        mem_pc_q      <= pc_q;
        mem_inst_q    <= inst_q;
        mem_rw_data_q <= wr_q ? addr_q : ld_val;
        mem_rw_addr_q <= rwa_q;
        mem_rw_en_q   <= rwe_q && !wr_q;
        mem_ale_q     <= 1'b0;
      end
    end
  end

  assign ts_valid    = ts_valid_q;
  assign dm_req      = (state_q == REQ);
  assign dm_wr       = dm_req && wr_q;
  assign dm_wstrb    = dm_req ? wstrb_q : 4'b0000;
  assign dm_addr     = {addr_q[DATA_W-1:2], 2'b00};
  assign dm_wdata    = wdata_q;
  assign mem_pc      = mem_pc_q;
  assign mem_inst    = mem_inst_q;
  assign mem_rw_data = mem_rw_data_q;
  assign mem_rw_addr = mem_rw_addr_q;
  assign mem_rw_en   = mem_rw_en_q;
  assign mem_ale     = mem_ale_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus randomized traffic checked
// every cycle against a transaction-level model of the stage.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid, ns_ready, flush, ts_ready, ts_valid;
  logic [31:0] ex_pc, ex_inst, ex_result, ex_st_data;
  logic [3:0]  ex_lsu_op;
  logic [4:0]  ex_rw_addr;
  logic        ex_rw_en;
  logic [31:0] mem_pc, mem_inst, mem_rw_data;
  logic [4:0]  mem_rw_addr;
  logic        mem_rw_en, mem_ale;
  logic        dm_req, dm_wr, dm_addr_ok, dm_data_ok;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .ts_ready(ts_ready), .ns_ready(ns_ready),
    .ts_valid(ts_valid), .flush(flush), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_result(ex_result), .ex_st_data(ex_st_data), .ex_lsu_op(ex_lsu_op),
    .ex_rw_addr(ex_rw_addr), .ex_rw_en(ex_rw_en), .mem_pc(mem_pc), .mem_inst(mem_inst),
    .mem_rw_data(mem_rw_data), .mem_rw_addr(mem_rw_addr), .mem_rw_en(mem_rw_en),
    .mem_ale(mem_ale), .dm_req(dm_req), .dm_wr(dm_wr), .dm_wstrb(dm_wstrb),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_addr_ok(dm_addr_ok),
    .dm_data_ok(dm_data_ok), .dm_rdata(dm_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc, inst, res, st;
    logic [3:0]  op;
    logic [4:0]  ra;
    logic        en;
  } instr_t;

  // model: bus request outstanding, response outstanding, response to discard
  bit          m_reqp, m_respp, m_disc, m_ov;
  int          lat;
  instr_t      m_txn;
  logic [31:0] e_pc, e_inst, e_data;
  logic [4:0]  e_ra;
  logic        e_en, e_ale;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [3:0] op);
    if (op == 1 || op == 4 || op == 6) return 1;
    if (op == 2 || op == 5 || op == 7) return 2;
    if (op == 3 || op == 8) return 4;
    return 0;
  endfunction

  function automatic bit is_store(input logic [3:0] op);
    return op >= 6 && op <= 8;
  endfunction

  function automatic bit misal(input logic [3:0] op, input logic [31:0] a);
    int sz = size_of(op);
    return sz != 0 && (a % sz) != 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    int    sz   = size_of(op);
    longint v   = (longint'(rd) >> (8 * (a % 4))) & ((64'd1 << (8 * sz)) - 1);
    longint lim = 64'd1 << (8 * sz - 1);
    if ((op == 1 || op == 2) && v >= lim) v = v - 2 * lim;
    return v[31:0];
  endfunction

  function automatic logic [31:0] wstrb_of(input logic [3:0] op, input logic [31:0] a);
    if (!is_store(op)) return 0;
    return ((32'd1 << size_of(op)) - 1) << (a % 4);
  endfunction

  function automatic logic [31:0] wdata_of(input logic [3:0] op, input logic [31:0] st);
    if (op == 6) return {24'd0, st[7:0]} * 32'h0101_0101;
    if (op == 7) return {16'd0, st[15:0]} * 32'h0001_0001;
    return st;
  endfunction

  function automatic bit exp_ready();
    return !m_reqp && !m_respp && (!m_ov || ns_ready);
  endfunction

  task automatic model_reset();
    m_reqp = 0; m_respp = 0; m_disc = 0; m_ov = 0; lat = 0;
  endtask

  task automatic compare();
    chk("ts_ready", {31'd0, ts_ready}, {31'd0, exp_ready()});
    chk("ts_valid", {31'd0, ts_valid}, {31'd0, m_ov});
    chk("dm_req", {31'd0, dm_req}, {31'd0, m_reqp});
    if (m_reqp) begin
      chk("dm_addr", dm_addr, m_txn.res & ~32'd3);
      chk("dm_wr", {31'd0, dm_wr}, {31'd0, is_store(m_txn.op)});
      chk("dm_wstrb", {28'd0, dm_wstrb}, wstrb_of(m_txn.op, m_txn.res));
      if (is_store(m_txn.op)) chk("dm_wdata", dm_wdata, wdata_of(m_txn.op, m_txn.st));
    end
    if (m_ov) begin
      chk("mem_pc", mem_pc, e_pc);
      chk("mem_inst", mem_inst, e_inst);
      chk("mem_rw_data", mem_rw_data, e_data);
      chk("mem_rw_addr", {27'd0, mem_rw_addr}, {27'd0, e_ra});
      chk("mem_rw_en", {31'd0, mem_rw_en}, {31'd0, e_en});
      chk("mem_ale", {31'd0, mem_ale}, {31'd0, e_ale});
    end
  endtask

  task automatic model_next();
    bit acc = ls_valid && exp_ready() && !flush;
    bit fin = 0;
    bit bad = misal(ex_lsu_op, ex_result);
    if (m_reqp) begin
      if (dm_addr_ok) begin
        m_reqp = 0;
        if (dm_data_ok) fin = !flush;
        else begin m_respp = 1; m_disc = flush; end
      end else if (flush) m_reqp = 0;
    end else if (m_respp) begin
      if (dm_data_ok) begin fin = !m_disc && !flush; m_respp = 0; m_disc = 0; end
      else if (flush) m_disc = 1;
    end
    if (flush) m_ov = 0;
    else if (fin) begin
      m_ov = 1; e_pc = m_txn.pc; e_inst = m_txn.inst; e_ra = m_txn.ra; e_ale = 0;
      if (is_store(m_txn.op)) begin e_data = m_txn.res; e_en = 0; end
      else begin e_data = load_val(m_txn.op, m_txn.res, dm_rdata); e_en = m_txn.en; end
    end else if (acc && (size_of(ex_lsu_op) == 0 || bad)) begin
      m_ov = 1; e_pc = ex_pc; e_inst = ex_inst; e_ra = ex_rw_addr;
      e_data = ex_result; e_en = ex_rw_en && !bad; e_ale = bad;
    end else if (ns_ready) m_ov = 0;
    if (acc && size_of(ex_lsu_op) != 0 && !bad) begin
      m_reqp = 1;
      m_txn = '{pc: ex_pc, inst: ex_inst, res: ex_result, st: ex_st_data,
                op: ex_lsu_op, ra: ex_rw_addr, en: ex_rw_en};
    end
  endtask

  // called at a negedge with inputs applied; leaves time at the next negedge
  task automatic step();
    #1;
    compare();
    model_next();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ls_valid = 0; flush = 0; ns_ready = 1; dm_addr_ok = 0; dm_data_ok = 0;
    ex_lsu_op = 0; dm_rdata = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] res, input logic [31:0] st);
    ls_valid = 1; ex_lsu_op = op; ex_result = res; ex_st_data = st;
    ex_pc = $urandom; ex_inst = $urandom; ex_rw_addr = 5'd7; ex_rw_en = 1;
  endtask

  task automatic rand_inputs();
    ls_valid   = ($urandom % 10) < 7;
    ex_pc      = $urandom; ex_inst = $urandom; ex_result = $urandom; ex_st_data = $urandom;
    ex_lsu_op  = 4'($urandom_range(0, 8));
    ex_rw_addr = 5'($urandom); ex_rw_en = 1'($urandom);
    ns_ready   = ($urandom % 10) < 6;
    flush      = ($urandom % 100) < 5;
    dm_rdata   = $urandom;
    dm_addr_ok = 0; dm_data_ok = 0;
    if (m_reqp) begin
      dm_addr_ok = ($urandom % 10) < 5;
      if (dm_addr_ok) begin
        if (($urandom % 10) < 3) dm_data_ok = 1;
        else lat = $urandom_range(0, 3);
      end else dm_data_ok = ($urandom % 10) == 0;
    end else if (m_respp) begin
      if (lat == 0) dm_data_ok = 1;
      else lat--;
    end else dm_data_ok = ($urandom % 10) == 0;
  endtask

  initial begin
    rst = 0; idle_inputs();
    ex_pc = 0; ex_inst = 0; ex_result = 0; ex_st_data = 0; ex_rw_addr = 0; ex_rw_en = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ts_valid", {31'd0, ts_valid}, 0);
    chk("rst_dm_req", {31'd0, dm_req}, 0);
    chk("rst_rw_en", {31'd0, mem_rw_en}, 0);
    chk("rst_ale", {31'd0, mem_ale}, 0);
    chk("rst_rw_data", mem_rw_data, 0);
    rst = 1;

    // LD_B 0x1003, same-cycle addr_ok/data_ok
    issue(4'd1, 32'h0000_1003, 0); step();
    idle_inputs(); dm_addr_ok = 1; dm_data_ok = 1; dm_rdata = 32'h80FF_0000; step();
    idle_inputs(); #1;
    chk("ldb_valid", {31'd0, ts_valid}, 1);
    chk("ldb_data", mem_rw_data, 32'hFFFF_FF80);
    chk("ldb_model", e_data, 32'hFFFF_FF80);
    chk("ldb_en", {31'd0, mem_rw_en}, 1);
    step();

    // ST_H 0x2002
    issue(4'd7, 32'h0000_2002, 32'h1234_ABCD); step();
    idle_inputs(); #1;
    chk("sth_wstrb", {28'd0, dm_wstrb}, 32'hC);
    chk("sth_wdata", dm_wdata, 32'hABCD_ABCD);
    chk("sth_addr", dm_addr, 32'h0000_2000);
    dm_addr_ok = 1; step();
    idle_inputs(); dm_data_ok = 1; step();
    idle_inputs(); #1;
    chk("sth_valid", {31'd0, ts_valid}, 1);
    chk("sth_en", {31'd0, mem_rw_en}, 0);
    step();

    // LD_W misaligned 0x3001
    issue(4'd3, 32'h0000_3001, 0); step();
    idle_inputs(); #1;
    chk("ale_req", {31'd0, dm_req}, 0);
    chk("ale_valid", {31'd0, ts_valid}, 1);
    chk("ale_flag", {31'd0, mem_ale}, 1);
    chk("ale_en", {31'd0, mem_rw_en}, 0);
    step();

    // LD_HU with slow addr_ok, delayed data_ok and back-pressure
    issue(4'd5, 32'h0000_4002, 0); step();
    idle_inputs();
    repeat (3) step();
    dm_addr_ok = 1; step();
    idle_inputs(); step();
    dm_data_ok = 1; dm_rdata = 32'hBEEF_1234; ns_ready = 0; step();
    idle_inputs(); ns_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1; chk("hu_hold", mem_rw_data, 32'h0000_BEEF);
      step();
    end
    ns_ready = 1; step();
    idle_inputs(); #1;
    chk("hu_drained", {31'd0, ts_valid}, 0);
    step();

    // flush in WAIT, data_ok three cycles later
    issue(4'd3, 32'h0000_5000, 0); step();
    idle_inputs(); dm_addr_ok = 1; step();
    idle_inputs(); flush = 1; step();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      #1; chk("cancel_rdy", {31'd0, ts_ready}, 0);
      step();
    end
    dm_data_ok = 1; step();
    idle_inputs(); #1;
    chk("cancel_done_rdy", {31'd0, ts_ready}, 1);
    chk("cancel_no_valid", {31'd0, ts_valid}, 0);
    step();

    // reset in the middle of WAIT
    issue(4'd3, 32'h0000_6000, 0); step();
    idle_inputs(); dm_addr_ok = 1; step();
    idle_inputs(); #2; rst = 0; #1;
    chk("mid_rst_req", {31'd0, dm_req}, 0);
    chk("mid_rst_valid", {31'd0, ts_valid}, 0);
    chk("mid_rst_en", {31'd0, mem_rw_en}, 0);
    model_reset();
    @(negedge clk); rst = 1; #1;
    chk("mid_rst_rdy", {31'd0, ts_ready}, 1);
    step();

    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
